// File: rtl/hilo_pkg.sv
// Shared definitions for the HI/LO unit: hilo_op bit positions, divider FSM
// states and the divider iteration count.
package hilo_pkg;

  // Bit positions inside the decoder's hilo_op vector (one-hot or zero).
  localparam int HILO_MFHI  = 7;
  localparam int HILO_MFLO  = 6;
  localparam int HILO_MTHI  = 5;
  localparam int HILO_MTLO  = 4;
  localparam int HILO_MULT  = 3;
  localparam int HILO_MULTU = 2;
  localparam int HILO_DIV   = 1;
  localparam int HILO_DIVU  = 0;

  // One quotient bit per iteration; tied to the 32-bit datapath.
  localparam int DIV_CYCLES = 32;
  localparam int CNT_W      = $clog2(DIV_CYCLES);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DIV  = 2'd1,
    ST_DONE = 2'd2
  } div_state_e;

endpackage

// File: rtl/div_iter.sv
// Iterative radix-2 restoring divider. Signed operands are reduced to
// magnitudes at start; quotient/remainder signs are restored on the output.
module div_iter
  import hilo_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic        flush_i,
  input  logic        signed_i,
  input  logic [31:0] dividend_i,
  input  logic [31:0] divisor_i,
  output logic        busy_o,
  output logic        iter_o,
  output logic        done_o,
  output logic [31:0] quotient_o,
  output logic [31:0] remainder_o
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DIV_CYCLES - 1);

  div_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [63:0]      rq_q, rq_d;      // {remainder, quotient} shift register
  logic [31:0]      dvs_q, dvs_d;    // divisor magnitude
  logic             q_neg_q, q_neg_d;
  logic             r_neg_q, r_neg_d;

  logic        dvd_neg, dvs_neg;
  logic [31:0] dvd_mag, dvs_mag;
  logic [32:0] trial;
  logic        success;
  logic [31:0] trial_diff;

  // Operand magnitudes; 0x8000_0000 negates to itself, which is the correct
  // unsigned magnitude. A zero divisor is never negative.
  assign dvd_neg = signed_i & dividend_i[31];
  assign dvs_neg = signed_i & divisor_i[31];
  assign dvd_mag = dvd_neg ? -dividend_i : dividend_i;
  assign dvs_mag = dvs_neg ? -divisor_i  : divisor_i;

  // One restoring step: upper 33 bits of the left-shifted register versus
  // the divisor. The partial remainder always stays below 2^32, so the
  // 32-bit difference is exact whenever the subtraction succeeds.
  assign trial      = rq_q[63:31];
  assign success    = (trial >= {1'b0, dvs_q});
  assign trial_diff = trial[31:0] - dvs_q;

  // Next-state and datapath update for the IDLE -> DIV -> DONE sequence.
  always_comb begin
    // NOTE: every variable gets a default first, so no path can infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    rq_d    = rq_q;
    dvs_d   = dvs_q;
    q_neg_d = q_neg_q;
    r_neg_d = r_neg_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d = ST_DIV;
          cnt_d   = '0;
          rq_d    = {32'd0, dvd_mag};
          dvs_d   = dvs_mag;
          q_neg_d = dvd_neg ^ dvs_neg;
          r_neg_d = dvd_neg;
        end
      end
      ST_DIV: begin
        rq_d  = success ? {trial_diff,  rq_q[30:0], 1'b1}
                        : {trial[31:0], rq_q[30:0], 1'b0};
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_CNT) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (flush_i) state_d = ST_IDLE;
  end

  // Divider state registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      rq_q    <= '0;
      dvs_q   <= '0;
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rq_q    <= rq_d;
      dvs_q   <= dvs_d;
      q_neg_q <= q_neg_d;
      r_neg_q <= r_neg_d;
    end
  end

  assign busy_o      = (state_q != ST_IDLE);
  assign iter_o      = (state_q == ST_DIV);
  assign done_o      = (state_q == ST_DONE);
  assign quotient_o  = q_neg_q ? -rq_q[31:0]  : rq_q[31:0];
  assign remainder_o = r_neg_q ? -rq_q[63:32] : rq_q[63:32];

endmodule

// File: rtl/hilo_unit.sv
// Execute-stage HI/LO unit: architectural HI/LO registers, single-cycle
// multiply and moves, iterative divide with pipeline stall, mfhi/mflo read.
module hilo_unit
  import hilo_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  input  logic        flush,
  input  logic [7:0]  hilo_op,
  input  logic [31:0] src1,
  input  logic [31:0] src2,
  output logic        stallreq,
  output logic [31:0] hilo_rdata,
  output logic        div_busy
);

  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  logic        commit;
  logic        is_div;
  logic        div_start;
  logic        div_iter_w;
  logic        div_done;
  logic [31:0] div_quot;
  logic [31:0] div_rem;
  logic [63:0] prod_s;
  logic [63:0] prod_u;

  assign commit    = ex_valid & ~flush;
  assign is_div    = hilo_op[HILO_DIV] | hilo_op[HILO_DIVU];
  // Only an idle divider accepts a new divide; a div still presented while
  // the result is being written (DONE) cannot restart it.
  assign div_start = commit & is_div & ~div_busy;
  assign stallreq  = div_start | div_iter_w;

  div_iter u_div_iter (
    .clk         (clk),
    .rst         (rst),
    .start_i     (div_start),
    .flush_i     (flush),
    .signed_i    (hilo_op[HILO_DIV]),
    .dividend_i  (src1),
    .divisor_i   (src2),
    .busy_o      (div_busy),
    .iter_o      (div_iter_w),
    .done_o      (div_done),
    .quotient_o  (div_quot),
    .remainder_o (div_rem)
  );

  // Full 64-bit products; sign-extending to 64 bits before multiplying gives
  // the signed product modulo 2^64, which is exactly the 64-bit result.
  assign prod_s = {{32{src1[31]}}, src1} * {{32{src2[31]}}, src2};
  assign prod_u = {32'd0, src1} * {32'd0, src2};

  // HI/LO write selection: divide result in DONE, single-cycle ops only
  // while the divider is idle (operands are ignored during a divide).
  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    if (commit) begin
      if (div_done) begin
        hi_d = div_rem;
        lo_d = div_quot;
      end else if (!div_busy) begin
        if (hilo_op[HILO_MTHI])       hi_d = src1;
        else if (hilo_op[HILO_MTLO])  lo_d = src1;
        else if (hilo_op[HILO_MULT])  {hi_d, lo_d} = prod_s;
        else if (hilo_op[HILO_MULTU]) {hi_d, lo_d} = prod_u;
      end
    end
  end

  // Architectural HI/LO registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end

  // Writes land at the end of EX, so reads simply return the register.
  assign hilo_rdata = hilo_op[HILO_MFHI] ? hi_q :
                      hilo_op[HILO_MFLO] ? lo_q : 32'd0;

endmodule

// File: tb/tb_hilo_unit.sv
// Self-checking bench for hilo_unit: directed cases plus randomized ops
// against an arithmetic reference model of HI/LO.
module tb_hilo_unit;

  localparam logic [7:0] OP_NONE  = 8'h00;
  localparam logic [7:0] OP_MFHI  = 8'h80;
  localparam logic [7:0] OP_MFLO  = 8'h40;
  localparam logic [7:0] OP_MTHI  = 8'h20;
  localparam logic [7:0] OP_MTLO  = 8'h10;
  localparam logic [7:0] OP_MULT  = 8'h08;
  localparam logic [7:0] OP_MULTU = 8'h04;
  localparam logic [7:0] OP_DIV   = 8'h02;
  localparam logic [7:0] OP_DIVU  = 8'h01;

  logic        clk;
  logic        rst;
  logic        ex_valid;
  logic        flush;
  logic [7:0]  hilo_op;
  logic [31:0] src1;
  logic [31:0] src2;
  logic        stallreq;
  logic [31:0] hilo_rdata;
  logic        div_busy;

  int          n_checks;
  int          n_errors;
  logic [31:0] hi_m;
  logic [31:0] lo_m;

  hilo_unit dut (
    .clk        (clk),
    .rst        (rst),
    .ex_valid   (ex_valid),
    .flush      (flush),
    .hilo_op    (hilo_op),
    .src1       (src1),
    .src2       (src2),
    .stallreq   (stallreq),
    .hilo_rdata (hilo_rdata),
    .div_busy   (div_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: full 64-bit product.
  function automatic logic [63:0] ref_mult(input logic [31:0] a, input logic [31:0] b,
                                           input bit sgn);
    longint pa, pb;
    if (sgn) begin
      pa = longint'($signed(a));
      pb = longint'($signed(b));
      return pa * pb;
    end
    return {32'd0, a} * {32'd0, b};
  endfunction

  // Reference: {remainder, quotient} using the architectural divide rules.
  function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b,
                                          input bit sgn);
    bit          na, nb;
    logic [31:0] ma, mb, q, r;
    na = sgn && a[31];
    nb = sgn && b[31];
    ma = na ? -a : a;
    mb = nb ? -b : b;
    if (mb == 0) begin
      q = 32'hFFFF_FFFF;
      r = ma;
    end else begin
      q = ma / mb;
      r = ma % mb;
    end
    if (na ^ nb) q = -q;
    if (na)      r = -r;
    return {r, q};
  endfunction

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 7))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'd1;
      default: return $urandom;
    endcase
  endfunction

  task automatic go_idle();
    ex_valid = 1'b0;
    flush    = 1'b0;
    hilo_op  = OP_NONE;
  endtask

  // Single-cycle op: never stalls; model updates at the issuing edge.
  task automatic do_single(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    ex_valid = 1'b1;
    flush    = 1'b0;
    hilo_op  = op;
    src1     = a;
    src2     = b;
    #1;
    check("single_stall", stallreq, 1'b0);
    case (op)
      OP_MTHI:  hi_m = a;
      OP_MTLO:  lo_m = a;
      OP_MULT:  {hi_m, lo_m} = ref_mult(a, b, 1'b1);
      OP_MULTU: {hi_m, lo_m} = ref_mult(a, b, 1'b0);
      default:  ;
    endcase
  endtask

  task automatic read_hilo(input string tag);
    @(negedge clk);
    ex_valid = 1'b1;
    flush    = 1'b0;
    hilo_op  = OP_MFHI;
    #1;
    check({tag, "_hi"}, hilo_rdata, hi_m);
    check({tag, "_stall"}, stallreq, 1'b0);
    hilo_op = OP_MFLO;
    #1;
    check({tag, "_lo"}, hilo_rdata, lo_m);
  endtask

  // Divide: count stall cycles (bounded), scramble operands while busy,
  // then confirm DONE does not retrigger.
  task automatic do_div(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                        input string tag);
    int n;
    @(negedge clk);
    ex_valid = 1'b1;
    flush    = 1'b0;
    hilo_op  = op;
    src1     = a;
    src2     = b;
    #1;
    n = 0;
    while (stallreq === 1'b1 && n < 40) begin
      n++;
      @(negedge clk);
      src1 = $urandom;
      src2 = $urandom;
      #1;
    end
    check({tag, "_stall_cycles"}, n, 33);
    check({tag, "_done_busy"}, div_busy, 1'b1);
    {hi_m, lo_m} = ref_div(a, b, op == OP_DIV);
    @(negedge clk);
    go_idle();
    #1;
    check({tag, "_no_retrigger"}, div_busy, 1'b0);
    read_hilo(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0;
    n_errors = 0;
    hi_m     = '0;
    lo_m     = '0;
    rst      = 1'b0;
    src1     = '0;
    src2     = '0;
    go_idle();
    hilo_op  = OP_MFHI;
    #1;
    check("reset_stall", stallreq, 1'b0);
    check("reset_busy", div_busy, 1'b0);
    check("reset_rdata", hilo_rdata, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    read_hilo("reset_regs");

    // Moves and multiplies.
    do_single(OP_MTHI, 32'h1234_5678, 32'd0);
    do_single(OP_MTLO, 32'h9ABC_DEF0, 32'd0);
    read_hilo("mthi_mtlo");
    check("mthi_abs", hi_m, 32'h1234_5678);
    do_single(OP_MULT, 32'hFFFF_FFFE, 32'h0000_0003);
    read_hilo("mult");
    check("mult_abs", {hi_m, lo_m}, 64'hFFFF_FFFF_FFFF_FFFA);
    do_single(OP_MULTU, 32'hFFFF_FFFE, 32'h0000_0003);
    read_hilo("multu");
    check("multu_abs", {hi_m, lo_m}, 64'h0000_0002_FFFF_FFFA);

    // Divides, including the called-out corner cases.
    do_div(OP_DIV, -32'sd7, 32'd2, "div_m7_2");
    check("div_m7_2_abs", {hi_m, lo_m}, 64'hFFFF_FFFF_FFFF_FFFD);
    do_div(OP_DIVU, 32'd100, 32'd7, "divu_100_7");
    check("divu_100_7_abs", {hi_m, lo_m}, {32'd2, 32'd14});
    do_div(OP_DIVU, 32'h1234, 32'd0, "divu_by0");
    check("divu_by0_abs", {hi_m, lo_m}, {32'h1234, 32'hFFFF_FFFF});
    do_div(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, "div_min_m1");
    check("div_min_m1_abs", {hi_m, lo_m}, {32'd0, 32'h8000_0000});

    // Flush during iteration 10.
    @(negedge clk);
    ex_valid = 1'b1;
    hilo_op  = OP_DIVU;
    src1     = 32'd1000;
    src2     = 32'd3;
    repeat (10) @(negedge clk);
    flush = 1'b1;
    #1;
    check("flush_busy_before", div_busy, 1'b1);
    @(negedge clk);
    go_idle();
    #1;
    check("flush_stall_after", stallreq, 1'b0);
    check("flush_busy_after", div_busy, 1'b0);
    read_hilo("flush_unchanged");
    do_div(OP_DIVU, 32'd1000, 32'd3, "divu_after_flush");

    // Flush together with an issuing op: nothing happens.
    @(negedge clk);
    ex_valid = 1'b1;
    flush    = 1'b1;
    hilo_op  = OP_MTHI;
    src1     = 32'hCAFE_F00D;
    @(negedge clk);
    hilo_op  = OP_DIV;
    src2     = 32'd5;
    #1;
    check("flush_issue_stall", stallreq, 1'b0);
    @(negedge clk);
    go_idle();
    #1;
    check("flush_issue_busy", div_busy, 1'b0);
    read_hilo("flush_issue_regs");

    // ex_valid low with a div bit set: no start, no stall.
    @(negedge clk);
    ex_valid = 1'b0;
    hilo_op  = OP_DIV;
    src1     = 32'd50;
    src2     = 32'd5;
    #1;
    check("novalid_stall", stallreq, 1'b0);
    @(negedge clk);
    #1;
    check("novalid_busy", div_busy, 1'b0);
    read_hilo("novalid_regs");

    // Asynchronous reset in the middle of a divide.
    do_single(OP_MTHI, 32'hDEAD_BEEF, 32'd0);
    do_single(OP_MTLO, 32'h0BAD_F00D, 32'd0);
    @(negedge clk);
    ex_valid = 1'b1;
    hilo_op  = OP_DIV;
    src1     = 32'd77;
    src2     = 32'd4;
    repeat (6) @(negedge clk);
    #2;
    ex_valid = 1'b0;
    hilo_op  = OP_MFHI;
    rst      = 1'b0;
    #1;
    hi_m = '0;
    lo_m = '0;
    check("rst_mid_stall", stallreq, 1'b0);
    check("rst_mid_busy", div_busy, 1'b0);
    check("rst_mid_hi", hilo_rdata, 32'd0);
    hilo_op = OP_MFLO;
    #1;
    check("rst_mid_lo", hilo_rdata, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    read_hilo("rst_regs");

    // Randomized traffic against the reference model.
    for (int i = 0; i < 40; i++) begin
      logic [31:0] a, b;
      a = rand_operand();
      b = rand_operand();
      case ($urandom_range(0, 5))
        0: do_single(OP_MTHI, a, b);
        1: do_single(OP_MTLO, a, b);
        2: do_single(OP_MULT, a, b);
        3: do_single(OP_MULTU, a, b);
        4: do_div(OP_DIV, a, b, "rand_div");
        default: do_div(OP_DIVU, a, b, "rand_divu");
      endcase
      read_hilo("rand");
    end

    @(negedge clk);
    go_idle();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/hilo_unit.md
# hilo_unit

Execute-stage HI/LO unit directly downstream of the instruction decoder: consumes the decoder's 8-bit `hilo_op` vector with the two ALU source operands and owns the architectural HI/LO registers. It executes `mult`/`multu` and `mthi`/`mtlo` in one cycle and `div`/`divu` iteratively over 33 cycles. It raises `stallreq` to the pipeline controller while a division is in flight, and returns HI/LO read data for `mfhi`/`mflo`.

## Interface
- `DIV_CYCLES`, 32 — iteration count of the radix-2 divider; fixed by the 32-bit datapath, not to be overridden.
- `clk`  in  1  — single clock; all state updates on the rising edge.
- `rst`  in  1  — asynchronous, active-low reset.
- `ex_valid`  in  1  — the instruction in EX is valid and may commit this cycle.
- `flush`  in  1  — pipeline flush (exception/eret); cancels any in-flight divide.
- `hilo_op`  in  8  — {mfhi, mflo, mthi, mtlo, mult, multu, div, divu}; at most one bit set.
- `src1`  in  32  — rs value: dividend, multiplicand, or mthi/mtlo data.
- `src2`  in  32  — rt value: divisor or multiplier.
- `stallreq`  out  1  — hold PC/IF/ID/EX; high while a divide is in progress.
- `hilo_rdata`  out  32  — HI when mfhi, LO when mflo, else 0; combinational.
- `div_busy`  out  1  — FSM not in IDLE (debug/perf).

## Operation
- State: 32-bit HI and LO; divider FSM IDLE → DIV → DONE → IDLE; 5-bit iteration counter; 64-bit remainder/quotient shift register; latched divisor, sign-of-quotient and sign-of-remainder flags.
- `mthi`: HI ← src1. `mtlo`: LO ← src1. Only the named register is written.
- `mult`: {HI,LO} ← signed 32×32 product. `multu`: unsigned. Full 64-bit result, no truncation.
- `div`/`divu`: LO ← quotient, HI ← remainder.
  - Signed: operate on magnitudes. Quotient is negated when the operand signs differ. Remainder takes the dividend's sign.
  - Magnitude of 0x8000_0000 is 0x8000_0000 as unsigned. 0x8000_0000 / −1 gives LO = 0x8000_0000, HI = 0.
  - Divide by zero is not trapped. The unsigned core yields quotient 0xFFFF_FFFF and remainder equal to the dividend magnitude, then the signed sign fix-up above applies (divisor zero counts as positive).
- Restoring division, one quotient bit per cycle, MSB first:
  - Shift the {rem,quot} register left by 1.
  - Trial-subtract the divisor from the upper 33 bits; restore the upper half if the result is negative.
  - Shift the quotient bit (1 = success) into the LSB.
- All HI/LO writes are gated by `ex_valid & ~flush`.
- Reads (mfhi/mflo) return the current register value. Writes commit at the end of the EX cycle, so no bypass is needed.

## Timing
- Reset: HI = LO = 0, FSM = IDLE, counter = 0, `stallreq` = 0, `div_busy` = 0, `hilo_rdata` = 0.
- mult/multu/mthi/mtlo: written at the edge ending the issue cycle; visible to mfhi/mflo in the next cycle. `stallreq` is never raised.
- div/divu issued in cycle 0 (IDLE, `ex_valid`, div bit set):
  - `stallreq` = 1 combinationally in cycle 0; operands are latched at that edge.
  - Cycles 1..32: FSM = DIV, one iteration per cycle, `stallreq` = 1.
  - Cycle 33: FSM = DONE, `stallreq` = 0; HI/LO are written at that edge and FSM returns to IDLE.
  - Result is readable from cycle 34 on.
- In DONE, the still-presented div instruction must not restart the divider.
- In DIV/DONE, changes on `hilo_op`, `src1` or `src2` are ignored.
- `flush` in any cycle:
  - FSM → IDLE and `stallreq` → 0 next cycle; no HI/LO write.
  - `flush` together with an issuing op: flush wins.
- `rst` asserted mid-divide: immediate return to reset values.
- `ex_valid` = 0 with a div bit set: no start, no stall.

## Structure
- Shared package `hilo_pkg`:
  - bit indices of `hilo_op` (HILO_MFHI = 7 … HILO_DIVU = 0);
  - FSM state typedef (IDLE, DIV, DONE);
  - `DIV_CYCLES`.
- Sub-module `div_iter` holds the iterative core: start/flush in; quotient, remainder and done out; signed handling included.
- `hilo_unit` itself holds HI/LO, the multiplier, the stall logic and the read mux.

## Test plan
- Reset, then mthi 0x1234_5678 and mtlo 0x9ABC_DEF0; mfhi/mflo next cycle → 0x1234_5678 / 0x9ABC_DEF0, `stallreq` never high.
- mult 0xFFFF_FFFE × 0x0000_0003 → HI = 0xFFFF_FFFF, LO = 0xFFFF_FFFA; the same operands with multu → HI = 0x0000_0002, LO = 0xFFFF_FFFA.
- div −7 / 2:
  - `stallreq` high exactly 33 cycles, low in cycle 33;
  - LO = 0xFFFF_FFFD, HI = 0xFFFF_FFFF;
  - divu 100 / 7 → LO = 14, HI = 2.
- divu 0x1234 / 0 → LO = 0xFFFF_FFFF, HI = 0x1234; div 0x8000_0000 / −1 → LO = 0x8000_0000, HI = 0.
- flush asserted in iteration 10 of a divide → `stallreq` low next cycle, HI/LO unchanged; a new divu then completes correctly in 33 cycles.
- `rst` pulsed low mid-divide → all outputs and HI/LO return to 0 immediately; a held div instruction in DONE does not retrigger.
